// File: rtl/pipe_pkg.sv
// Shared types and EX/MEM control-bundle layout for flow-controlled pipeline stages.
// Bubbles carry EXMEM_CTRL_SAFE so they can never write the register file or memory.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int EXMEM_DATA_W = 160;
  localparam int EXMEM_CTRL_W = 13;

  // Field positions inside the 13-bit EX/MEM control bundle, MSB first.
  localparam int REGWRITE_BIT   = 12;
  localparam int MEMWRITE_BIT   = 11;
  localparam int RESULTSRC_LSB  = 8;
  localparam int LOADSRC_LSB    = 5;
  localparam int RD_LSB         = 0;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic [2:0] loadsrc;
    logic [4:0] rd;
  } exmem_ctrl_t;

  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_SAFE = '0;

  function automatic logic ctrl_has_side_effect(input logic [EXMEM_CTRL_W-1:0] ctrl);
    return ctrl[REGWRITE_BIT] | ctrl[MEMWRITE_BIT];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage: data plus control, with load enable and a
// control-only clear used when the slot is vacated or flushed.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = EXMEM_DATA_W,
  parameter int                 CTRL_W    = EXMEM_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_SAFE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear wins over load; data is left alone on clear since it is don't-care once empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      ctrl <= CTRL_SAFE;
    end else if (clear) begin
      ctrl <= CTRL_SAFE;
    end else if (load) begin
      data <= load_data;
      ctrl <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer, flush,
// bubble-safe control gating and a saturating downstream-stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = EXMEM_DATA_W,
  parameter int                 CTRL_W    = EXMEM_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_SAFE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t state;
  state_t state_next;

  logic in_fire;
  logic out_fire;

  logic main_load;
  logic main_clear;
  logic main_from_skid;
  logic skid_load;
  logic skid_clear;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_load_data;
  logic [CTRL_W-1:0] main_load_ctrl;

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready  = (state != FULL) & ~rst;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_next = HALF;
        HALF: begin
          if (in_fire && !out_fire)      state_next = FULL;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        FULL:  if (out_fire) state_next = HALF;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Slot steering; a flush vacates both slots and discards this cycle's in_fire.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = in_fire;
        HALF: begin
          if (in_fire && out_fire) main_load  = 1'b1;
          else if (in_fire)        skid_load  = 1'b1;
          else if (out_fire)       main_clear = 1'b1;
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_SAFE (CTRL_SAFE)
  ) main_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_SAFE (CTRL_SAFE)
  ) skid_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  assign out_data = main_data;
  assign out_ctrl = out_valid ? main_ctrl : CTRL_SAFE;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus randomized bench for pipe_stage_skid against a queue-based model;
// a second instance with a 4-bit counter exercises stall-count saturation.
module tb_pipe_stage_skid;

  localparam int DW = 160;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;

  logic          sat_in_ready, sat_out_valid;
  logic [DW-1:0] sat_out_data;
  logic [CW-1:0] sat_out_ctrl;
  logic [3:0]    sat_stall_cnt;

  int total = 0;
  int bad   = 0;

  // Model: FIFO of {data, ctrl} entries with capacity two, plus stall counts.
  logic [DW+CW-1:0] q[$];
  int unsigned cnt16 = 0;
  int unsigned cnt4  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
    .stall_cnt(sat_stall_cnt)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic          exp_valid;
    logic [CW-1:0] exp_ctrl;
    exp_valid = (q.size() > 0);
    exp_ctrl  = exp_valid ? q[0][CW-1:0] : '0;
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, (!rst && q.size() < 2));
    chk("out_ctrl", out_ctrl, exp_ctrl);
    chk("stall_cnt", stall_cnt, cnt16);
    chk("sat_stall_cnt", sat_stall_cnt, cnt4);
    chk("sat_out_ctrl", sat_out_ctrl, exp_ctrl);
    chk("sat_in_ready", sat_in_ready, (!rst && q.size() < 2));
    if (exp_valid) begin
      chk("out_data", out_data, q[0][DW+CW-1:CW]);
      chk("sat_out_data", sat_out_data, q[0][DW+CW-1:CW]);
    end
  endtask

  // Drive one cycle from a negedge, check before the edge, then advance the model.
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, output logic accepted);
    logic inf, outf, stall;
    rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    #1;
    checkOutput();
    inf   = iv && !r && (q.size() < 2);
    outf  = (q.size() > 0) && ordy;
    stall = !r && !f && (q.size() > 0) && !ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      if (stall) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (f) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back({d, c});
      end
    end
    accepted = inf;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, ordy, acc);
  endtask

  // Offer one entry until accepted, within a bounded number of cycles.
  task automatic sendHold(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b1, d, c, ordy, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset: second rst cycle with valid input offered, must not be taken.
    applyStimulus(1'b1, 1'b0, 1'b1, DW'(32'hA5A5), 13'h1FFF, 1'b0, acc);
    chk("reset_out_data", out_data, '0);

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, DW'(i), 13'(13'h101 | i), 1'b1, acc);
    // Bubbles.
    idle(1'b1, 3);

    // Backpressure: A into main, B into skid, C held upstream.
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'hA), 13'h10A, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'hB), 13'h10B, 1'b0, acc);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'hC), 13'h10C, 1'b0, acc);
    sendHold(DW'(32'hC), 13'h10C, 1'b1);
    idle(1'b1, 4);

    // Flush at FULL with a new entry offered.
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h1A), 13'h1FFA, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h1B), 13'h1FFB, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b1, DW'(32'h1C), 13'h1FFC, 1'b0, acc);
    idle(1'b1, 2);

    // rst and flush together while FULL.
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h2A), 13'h0AA, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h2B), 13'h0BB, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, DW'(32'h2C), 13'h0CC, 1'b0, acc);
    idle(1'b1, 2);

    // Saturation: 20 stalled cycles on a held entry.
    applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'h3A), 13'h13A, 1'b0, acc);
    idle(1'b0, 20);
    chk("sat_hold_15", sat_stall_cnt, 4'd15);
    chk("stall_cnt_wide", stall_cnt, 16'd20);
    idle(1'b1, 2);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) != 0), rand_data(), 13'($urandom_range(0, 8191)),
                    ($urandom_range(0, 2) != 0), acc);
    end
    idle(1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
